fsic_wb_arbiter: RTL and testbench
==================================

// Module: fsic_wb_arbiter
// PURPOSE
// - Two-master, one-target Wishbone (classic, single-beat) arbiter in front of the FSIC config/user port.
// - Shares the port between m0 (mgmt SoC WB) and m1 (secondary/debug master).
// - Round-robin grant, one transaction per grant, optional hang timeout with error completion.
// PARAMETERS
// - ADDR_W        32            address width
// - DATA_W        32            data width; SEL width = DATA_W/8
// - TIMEOUT_CYC   255           BUSY cycles without s_ack before forced completion (WB_ARB_TIMEOUT_EN only)
// - TIMEOUT_DATA  32'hDEAD_BEEF rdata returned on timeout completion
// PORTS
// - wb_clk      in   1        single clock
// - wb_rst_n    in   1        asynchronous active-low reset
// - m{0,1}_cyc  in   1        master cycle
// - m{0,1}_stb  in   1        master strobe
// - m{0,1}_we   in   1        master write enable
// - m{0,1}_sel  in   DATA_W/8 byte selects
// - m{0,1}_adr  in   ADDR_W   address
// - m{0,1}_wdata in  DATA_W   write data
// - m{0,1}_ack  out  1        completion to master
// - m{0,1}_rdata out DATA_W   read data to master
// - s_cyc, s_stb, s_we  out 1 target controls
// - s_sel       out  DATA_W/8 target byte selects
// - s_adr       out  ADDR_W   target address
// - s_wdata     out  DATA_W   target write data
// - s_ack       in   1        target completion
// - s_rdata     in   DATA_W   target read data
// - timeout_o   out  1        one-cycle pulse on timeout completion
// BEHAVIOUR
// - req_i = m_i_cyc & m_i_stb. FSM IDLE/BUSY. grant register (0/1) and last_grant register.
// - Reset: IDLE, grant=0, last_grant=1 (m0 wins the first tie), counter=0. All outputs 0.
// - IDLE: single requester -> granted. Both -> the master != last_grant. Go BUSY next edge.
// - Latency: request sampled at edge N, s_cyc/s_stb high from cycle N+1.
// - BUSY: s_* muxed from the granted master. s_cyc=m_g_cyc and s_stb=m_g_stb.
// - m_g_ack = s_ack & BUSY, combinational pass-through. m_g_rdata = s_rdata.
// - Non-granted master: ack=0, rdata=0.
// - On s_ack in BUSY: last_grant<=grant, next state IDLE. Every transaction is followed by at least one IDLE cycle.
// - Abort: granted master drops cyc in BUSY -> IDLE next edge, no ack forwarded, last_grant updated.
// - s_ack in IDLE: ignored, never forwarded.
// - A master holding stb across its own ack is treated as a new request in the following IDLE cycle.
// - Async reset mid-transaction: immediate IDLE, s_cyc/s_stb/acks drop in the same cycle.
// CONFIGURATION
// - WB_ARB_TIMEOUT_EN defined:
//   - counter clears on entering BUSY and increments each BUSY cycle without s_ack.
//   - When count == TIMEOUT_CYC-1 and still no s_ack: that cycle drives m_g_ack=1, m_g_rdata=TIMEOUT_DATA, timeout_o=1.
//   - In that cycle s_cyc/s_stb=0 and last_grant<=grant; next state IDLE.
//   - s_ack in the same cycle wins: normal completion, no timeout.
// - WB_ARB_TIMEOUT_EN undefined: no counter; timeout_o tied 0; BUSY waits indefinitely for s_ack or abort.
// STRUCTURE
// - fsic_wb_arb_pkg:
//   - state enum {ARB_IDLE, ARB_BUSY}
//   - GRANT_M0/GRANT_M1 localparams
//   - default TIMEOUT_DATA constant
// - Sub-module fsic_wb_arb_rr: 2-way round-robin picker (req[1:0], last_grant -> gnt_valid, gnt).
// - Top holds the FSM, grant/last_grant registers, timeout counter and s_*/m_* muxes.
// TESTING
// - Single m0 write adr=0x3000_0004 wdata=0x1234_5678, s_ack 2 cycles after s_stb -> s_* match m0, m0_ack same cycle, m1_ack never.
// - m0 and m1 request in the same cycle after reset -> m0 granted first, m1 granted after one IDLE cycle. Repeat the tie -> m1 granted first (alternation).
// - m1 read, s_rdata=0xCAFE_F00D with s_ack -> m1_rdata=0xCAFE_F00D, m0_rdata=0 throughout.
// - m0 drops cyc in BUSY before s_ack -> s_cyc low next cycle, no m0_ack, a pending m1 request is granted next.
// - WB_ARB_TIMEOUT_EN with TIMEOUT_CYC=8, s_ack never asserted -> in BUSY cycle 8 m0_ack=1, m0_rdata=0xDEAD_BEEF, timeout_o=1 for one cycle. Without the macro -> stays BUSY.
// - wb_rst_n pulsed low mid-BUSY -> all outputs 0 asynchronously. After release, a tie is granted to m0.

Source files
------------

// File: rtl/fsic_wb_arb_pkg.sv
// Shared types and constants for the FSIC Wishbone two-master arbiter.
// Optional hang timeout is enabled by defining WB_ARB_TIMEOUT_EN.
package fsic_wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Two-way round-robin choice: a lone requester wins, a tie goes to
  // whichever master was not served last.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    logic pick;
    if (req == 2'b11) begin
      pick = ~last_grant;
    end else if (req[1]) begin
      pick = GRANT_M1;
    end else begin
      pick = GRANT_M0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/fsic_wb_arb_rr.sv
// Two-way round-robin picker used by the FSIC Wishbone arbiter.
module fsic_wb_arb_rr
  import fsic_wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt
);

  // Pure combinational choice; the caller decides when to latch it.
  always_comb begin
    gnt_valid = |req;
    gnt       = rr_pick(req, last_grant);
  end

endmodule

// File: rtl/fsic_wb_arbiter.sv
// Two-master, one-target classic Wishbone arbiter for the FSIC config port.
// Round-robin grant, one transaction per grant, at least one IDLE cycle
// between transactions. Define WB_ARB_TIMEOUT_EN to enable the hang timeout
// that completes a stuck transaction with TIMEOUT_DATA and pulses timeout_o.
module fsic_wb_arbiter
  import fsic_wb_arb_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                TIMEOUT_CYC  = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(DEFAULT_TIMEOUT_DATA)
) (
  input  logic                wb_clk,
  input  logic                wb_rst_n,
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic [ADDR_W-1:0]   m0_adr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic [ADDR_W-1:0]   m1_adr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [DATA_W/8-1:0] s_sel,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic                s_ack,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                timeout_o
);

  localparam int SEL_W = DATA_W / 8;

  if (TIMEOUT_CYC < 1 || (DATA_W % 8) != 0) begin : g_param_check
    $error("fsic_wb_arbiter: TIMEOUT_CYC must be >= 1 and DATA_W a multiple of 8");
  end

  arb_state_t        state_reg;
  arb_state_t        state_next;
  logic              grant_reg;
  logic              last_grant_reg;
  logic [1:0]        req;
  logic              gnt_valid;
  logic              gnt;
  logic              busy;
  logic              done;
  logic              to_fire;
  logic              g_cyc;
  logic              g_stb;
  logic              g_we;
  logic [SEL_W-1:0]  g_sel;
  logic [ADDR_W-1:0] g_adr;
  logic [DATA_W-1:0] g_wdata;

  assign req  = {m1_cyc & m1_stb, m0_cyc & m0_stb};
  assign busy = (state_reg == ARB_BUSY);

  fsic_wb_arb_rr u_rr (
    .req        (req),
    .last_grant (last_grant_reg),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  // Select the bus signals of whichever master currently holds the grant.
  always_comb begin
    if (grant_reg == GRANT_M1) begin
      g_cyc   = m1_cyc;
      g_stb   = m1_stb;
      g_we    = m1_we;
      g_sel   = m1_sel;
      g_adr   = m1_adr;
      g_wdata = m1_wdata;
    end else begin
      g_cyc   = m0_cyc;
      g_stb   = m0_stb;
      g_we    = m0_we;
      g_sel   = m0_sel;
      g_adr   = m0_adr;
      g_wdata = m0_wdata;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] count_reg;

  // Count BUSY cycles without a target ack; IDLE holds zero so each grant starts fresh.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      count_reg <= '0;
    end else if (state_reg == ARB_IDLE) begin
      count_reg <= '0;
    end else if (!s_ack) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // A real ack in the last allowed cycle wins; an abort also takes precedence.
  assign to_fire = busy && g_cyc && !s_ack && (count_reg == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign to_fire = 1'b0;
`endif

  // A transaction ends on target ack, master abort or forced timeout.
  assign done = busy && (s_ack || !g_cyc || to_fire);

  // State register.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: grant from IDLE, return to IDLE once the transaction ends.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: if (gnt_valid) state_next = ARB_BUSY;
      ARB_BUSY: if (done)      state_next = ARB_IDLE;
    endcase
  end

  // Latch the winner on leaving IDLE; remember who was served when it finishes.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      grant_reg      <= GRANT_M0;
      last_grant_reg <= GRANT_M1;
    end else begin
      if (state_reg == ARB_IDLE && gnt_valid) begin
        grant_reg <= gnt;
      end
      if (done) begin
        last_grant_reg <= grant_reg;
      end
    end
  end

  // Output muxing: everything idles at zero outside BUSY, so s_ack in IDLE is never forwarded.
  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_sel     = '0;
    s_adr     = '0;
    s_wdata   = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    timeout_o = 1'b0;
    if (busy) begin
      s_cyc     = g_cyc & ~to_fire;
      s_stb     = g_stb & ~to_fire;
      s_we      = g_we;
      s_sel     = g_sel;
      s_adr     = g_adr;
      s_wdata   = g_wdata;
      timeout_o = to_fire;
      if (grant_reg == GRANT_M1) begin
        m1_ack   = s_ack | to_fire;
        m1_rdata = to_fire ? TIMEOUT_DATA : s_rdata;
      end else begin
        m0_ack   = s_ack | to_fire;
        m0_rdata = to_fire ? TIMEOUT_DATA : s_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fsic_wb_arbiter.sv
// Directed table-driven bench for fsic_wb_arbiter plus hand-written
// sequences for timeout (WB_ARB_TIMEOUT_EN aware) and async reset.
module tb_fsic_wb_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z32  = 32'h0000_0000;
  localparam logic [31:0] A_T0 = 32'h3000_0010;
  localparam logic [31:0] W_T0 = 32'hA1A1_A1A1;
  localparam logic [31:0] A_T1 = 32'h3000_0020;
  localparam logic [31:0] W_T1 = 32'hB2B2_B2B2;
  localparam logic [31:0] A_W  = 32'h3000_0004;
  localparam logic [31:0] W_W  = 32'h1234_5678;
  localparam logic [31:0] A_R  = 32'h3000_0040;
  localparam logic [31:0] A_AB = 32'h3000_0008;
  localparam logic [31:0] W_AB = 32'h0C0C_0C0C;
  localparam int NV = 22;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [3:0]  m0_sel = 4'h0;
  logic [31:0] m0_adr = '0, m0_wdata = '0;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [3:0]  m1_sel = 4'h0;
  logic [31:0] m1_adr = '0, m1_wdata = '0;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdata;
  logic        s_ack = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        timeout_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fsic_wb_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .wb_clk    (clk),
    .wb_rst_n  (rst_n),
    .m0_cyc    (m0_cyc),
    .m0_stb    (m0_stb),
    .m0_we     (m0_we),
    .m0_sel    (m0_sel),
    .m0_adr    (m0_adr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m1_cyc    (m1_cyc),
    .m1_stb    (m1_stb),
    .m1_we     (m1_we),
    .m1_sel    (m1_sel),
    .m1_adr    (m1_adr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_sel     (s_sel),
    .s_adr     (s_adr),
    .s_wdata   (s_wdata),
    .s_ack     (s_ack),
    .s_rdata   (s_rdata),
    .timeout_o (timeout_o)
  );

  typedef struct {
    string       nm;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_adr;
    logic [31:0] m0_wdata;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_adr;
    logic [31:0] m1_wdata;
    logic        s_ack;
    logic [31:0] s_rdata;
    logic        e_cyc;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_adr;
    logic [31:0] e_wdata;
    logic        e_ack0;
    logic        e_ack1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(
    input string nm,
    input logic m0r, input logic m0w, input logic [31:0] m0a, input logic [31:0] m0d,
    input logic m1r, input logic m1w, input logic [31:0] m1a, input logic [31:0] m1d,
    input logic ack, input logic [31:0] rd,
    input logic ec, input logic ew, input logic [3:0] es, input logic [31:0] ea, input logic [31:0] ed,
    input logic ea0, input logic ea1, input logic [31:0] er0, input logic [31:0] er1);
    vec_t v;
    v.nm = nm;
    v.m0_req = m0r; v.m0_we = m0w; v.m0_adr = m0a; v.m0_wdata = m0d;
    v.m1_req = m1r; v.m1_we = m1w; v.m1_adr = m1a; v.m1_wdata = m1d;
    v.s_ack = ack; v.s_rdata = rd;
    v.e_cyc = ec; v.e_we = ew; v.e_sel = es; v.e_adr = ea; v.e_wdata = ed;
    v.e_ack0 = ea0; v.e_ack1 = ea1; v.e_rd0 = er0; v.e_rd1 = er1;
    return v;
  endfunction

  task automatic drive(input logic m0r, input logic m0w, input logic [31:0] m0a, input logic [31:0] m0d,
                       input logic m1r, input logic m1w, input logic [31:0] m1a, input logic [31:0] m1d,
                       input logic ack, input logic [31:0] rd);
    m0_cyc = m0r; m0_stb = m0r; m0_we = m0w; m0_adr = m0a; m0_wdata = m0d; m0_sel = 4'hF;
    m1_cyc = m1r; m1_stb = m1r; m1_we = m1w; m1_adr = m1a; m1_wdata = m1d; m1_sel = 4'h3;
    s_ack = ack; s_rdata = rd;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [137:0] pack_out();
    return {s_cyc, s_stb, s_we, s_sel, s_adr, s_wdata, m0_ack, m1_ack, m0_rdata, m1_rdata, timeout_o};
  endfunction

  // Leaves the bench at posedge+1 with reset released away from the edge.
  task automatic do_reset();
    drive(L, L, Z32, Z32, L, L, Z32, Z32, L, Z32);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [137:0] exp_v;

    // Tie after reset -> m0, m0 re-requests -> m1, tie again -> m0.
    vecs[0]  = mk("tie_idle", H,L,A_T0,W_T0, H,H,A_T1,W_T1, L,Z32,           L,L,4'h0,Z32,Z32,  L,L,Z32,Z32);
    vecs[1]  = mk("tie_m0",   H,L,A_T0,W_T0, H,H,A_T1,W_T1, H,32'h1111_1111, H,L,4'hF,A_T0,W_T0, H,L,32'h1111_1111,Z32);
    vecs[2]  = mk("tie_gap",  H,L,A_T0,W_T0, H,H,A_T1,W_T1, H,32'h2222_2222, L,L,4'h0,Z32,Z32,  L,L,Z32,Z32);
    vecs[3]  = mk("tie_m1",   H,L,A_T0,W_T0, H,H,A_T1,W_T1, H,32'h3333_3333, H,H,4'h3,A_T1,W_T1, L,H,Z32,32'h3333_3333);
    vecs[4]  = mk("tie_gap2", H,L,A_T0,W_T0, H,H,A_T1,W_T1, L,Z32,           L,L,4'h0,Z32,Z32,  L,L,Z32,Z32);
    vecs[5]  = mk("tie_m0b",  H,L,A_T0,W_T0, H,H,A_T1,W_T1, H,32'h4444_4444, H,L,4'hF,A_T0,W_T0, H,L,32'h4444_4444,Z32);
    vecs[6]  = mk("tie_end",  L,L,Z32,Z32,   L,L,Z32,Z32,   L,Z32,           L,L,4'h0,Z32,Z32,  L,L,Z32,Z32);
    // m0 write, target acks two cycles after strobe.
    vecs[7]  = mk("wr_req",   H,H,A_W,W_W,   L,L,Z32,Z32,   L,Z32,           L,L,4'h0,Z32,Z32,  L,L,Z32,Z32);
    vecs[8]  = mk("wr_b1",    H,H,A_W,W_W,   L,L,Z32,Z32,   L,Z32,           H,H,4'hF,A_W,W_W,  L,L,Z32,Z32);
    vecs[9]  = mk("wr_b2",    H,H,A_W,W_W,   L,L,Z32,Z32,   L,Z32,           H,H,4'hF,A_W,W_W,  L,L,Z32,Z32);
    vecs[10] = mk("wr_ack",   H,H,A_W,W_W,   L,L,Z32,Z32,   H,Z32,           H,H,4'hF,A_W,W_W,  H,L,Z32,Z32);
    vecs[11] = mk("wr_end",   L,L,Z32,Z32,   L,L,Z32,Z32,   L,Z32,           L,L,4'h0,Z32,Z32,  L,L,Z32,Z32);
    // m1 read returning CAFE_F00D.
    vecs[12] = mk("rd_req",   L,L,Z32,Z32,   H,L,A_R,W_T1,  L,Z32,           L,L,4'h0,Z32,Z32,  L,L,Z32,Z32);
    vecs[13] = mk("rd_b1",    L,L,Z32,Z32,   H,L,A_R,W_T1,  L,Z32,           H,L,4'h3,A_R,W_T1, L,L,Z32,Z32);
    vecs[14] = mk("rd_ack",   L,L,Z32,Z32,   H,L,A_R,W_T1,  H,32'hCAFE_F00D, H,L,4'h3,A_R,W_T1, L,H,Z32,32'hCAFE_F00D);
    vecs[15] = mk("rd_end",   L,L,Z32,Z32,   L,L,Z32,Z32,   L,Z32,           L,L,4'h0,Z32,Z32,  L,L,Z32,Z32);
    // m0 aborts mid-BUSY, pending m1 is served next.
    vecs[16] = mk("ab_req",   H,H,A_AB,W_AB, L,L,Z32,Z32,   L,Z32,           L,L,4'h0,Z32,Z32,  L,L,Z32,Z32);
    vecs[17] = mk("ab_b1",    H,H,A_AB,W_AB, H,L,A_R,W_T1,  L,Z32,           H,H,4'hF,A_AB,W_AB, L,L,Z32,Z32);
    vecs[18] = mk("ab_drop",  L,H,A_AB,W_AB, H,L,A_R,W_T1,  L,Z32,           L,H,4'hF,A_AB,W_AB, L,L,Z32,Z32);
    vecs[19] = mk("ab_idle",  L,L,Z32,Z32,   H,L,A_R,W_T1,  L,Z32,           L,L,4'h0,Z32,Z32,  L,L,Z32,Z32);
    vecs[20] = mk("ab_m1",    L,L,Z32,Z32,   H,L,A_R,W_T1,  H,32'h5555_5555, H,L,4'h3,A_R,W_T1, L,H,Z32,32'h5555_5555);
    vecs[21] = mk("ab_end",   L,L,Z32,Z32,   L,L,Z32,Z32,   L,Z32,           L,L,4'h0,Z32,Z32,  L,L,Z32,Z32);

    do_reset();
    #3;
    chk("reset_outputs", 160'(pack_out()), 160'(0));
    $display("reset checked");
    next_cyc();

    for (int i = 0; i < NV; i++) begin
      if (i != 0) next_cyc();
      drive(vecs[i].m0_req, vecs[i].m0_we, vecs[i].m0_adr, vecs[i].m0_wdata,
            vecs[i].m1_req, vecs[i].m1_we, vecs[i].m1_adr, vecs[i].m1_wdata,
            vecs[i].s_ack, vecs[i].s_rdata);
      #3;
      exp_v = {vecs[i].e_cyc, vecs[i].e_cyc, vecs[i].e_we, vecs[i].e_sel, vecs[i].e_adr, vecs[i].e_wdata,
               vecs[i].e_ack0, vecs[i].e_ack1, vecs[i].e_rd0, vecs[i].e_rd1, L};
      chk(vecs[i].nm, 160'(pack_out()), 160'(exp_v));
      $display("vec %0d %s checked", i, vecs[i].nm);
    end

    // Hang: m0 read that the target never acks.
    do_reset();
    drive(H, L, A_T0, W_T0, L, L, Z32, Z32, L, Z32);
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      next_cyc();
      #3;
      if (k < 8) begin
        chk($sformatf("to_wait%0d", k), 160'({s_cyc, s_stb, m0_ack, m1_ack, timeout_o, m0_rdata}),
            160'({H, H, L, L, L, Z32}));
      end else begin
        chk("to_fire", 160'({s_cyc, s_stb, m0_ack, m1_ack, timeout_o, m0_rdata}),
            160'({L, L, H, L, H, 32'hDEAD_BEEF}));
      end
    end
    next_cyc();
    drive(L, L, Z32, Z32, L, L, Z32, Z32, L, Z32);
    #3;
    chk("to_after", 160'({s_cyc, m0_ack, timeout_o}), 160'({L, L, L}));
    $display("timeout sequence checked");
`else
    for (int k = 1; k <= 20; k++) begin
      next_cyc();
      #3;
      chk($sformatf("hang%0d", k), 160'({s_cyc, s_stb, m0_ack, m1_ack, timeout_o, m0_rdata}),
          160'({H, H, L, L, L, Z32}));
    end
    next_cyc();
    drive(L, L, Z32, Z32, L, L, Z32, Z32, L, Z32);
    #3;
    chk("hang_abort", 160'({s_cyc, s_stb, m0_ack, timeout_o}), 160'({L, L, L, L}));
    next_cyc();
    #3;
    chk("hang_idle", 160'({s_cyc, m0_ack, timeout_o}), 160'({L, L, L}));
    $display("hang sequence checked");
`endif

    // Async reset in the middle of an m1 transaction, after m0 was served last.
    do_reset();
    drive(H, H, A_W, W_W, L, L, Z32, Z32, L, Z32);
    next_cyc();
    s_ack = H;
    #3;
    chk("rst_m0_done", 160'({s_cyc, m0_ack}), 160'({H, H}));
    next_cyc();
    drive(L, L, Z32, Z32, H, L, A_R, W_T1, L, Z32);
    next_cyc();
    #3;
    chk("rst_m1_busy", 160'({s_cyc, s_adr, m1_ack}), 160'({H, A_R, L}));
    #2;
    rst_n = 1'b0;
    s_ack = H;
    #1;
    chk("rst_async_zero", 160'(pack_out()), 160'(0));
    #1;
    rst_n = 1'b1;
    drive(H, L, A_T0, W_T0, H, H, A_T1, W_T1, L, Z32);
    #1;
    chk("rst_release_idle", 160'(pack_out()), 160'(0));
    next_cyc();
    #3;
    chk("rst_tie_m0", 160'({s_cyc, s_we, s_sel, s_adr}), 160'({H, L, 4'hF, A_T0}));
    $display("async reset sequence checked");

    next_cyc();
    drive(L, L, Z32, Z32, L, L, Z32, Z32, L, Z32);
    repeat (2) next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
